// File: rtl/rank_pkg.sv
// rtl/rank_pkg.sv - shared event code, FSM state type and empty-score fill for the rank table
package rank_pkg;

  localparam logic [3:0] PUN_CODE = 4'b1000;

  // Truncated to PUN_BITS at the point of use, so any score width reads all-ones when empty.
  localparam logic [31:0] EMPTY_SCORE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } rank_state_e;

endpackage

// File: rtl/pun_edge.sv
// rtl/pun_edge.sv - score-event match with rising-edge detect; one req per held code
module pun_edge
  import rank_pkg::*;
#(
  parameter int MENS_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MENS_BITS-1:0] data,
  output logic                 req
);

  logic match;
  logic match_q;

  assign match = (data == MENS_BITS'(PUN_CODE));

  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match;
    end
  end

  // An edge coinciding with reset is suppressed rather than left to the consumer.
  assign req = match & ~match_q & ~rst;

endmodule

// File: rtl/rank_table.sv
// rtl/rank_table.sv - sorted table of the DEPTH lowest scores, filled by insertion shift
module rank_table
  import rank_pkg::*;
#(
  parameter int MENS_BITS = 4,
  parameter int PUN_BITS  = 7,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MENS_BITS-1:0]       data,
  input  logic [PUN_BITS-1:0]        pun,
  input  logic                       clear,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [PUN_BITS-1:0]        rd_pun,
  output logic [PUN_BITS-1:0]        mpun,
  output logic [PUN_BITS-1:0]        apun,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic                       new_best
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]       DEPTH_C  = CW'(DEPTH);
  localparam logic [IW-1:0]       LAST_IDX = IW'(DEPTH - 1);
  localparam logic [PUN_BITS-1:0] EMPTY    = PUN_BITS'(EMPTY_SCORE);

  rank_state_e         state;
  logic [PUN_BITS-1:0] slot [DEPTH];
  logic [DEPTH-1:0]    valid;
  logic [PUN_BITS-1:0] new_s;
  logic [PUN_BITS-1:0] apun_r;
  logic [IW-1:0]       ptr;
  logic [CW-1:0]       count_r;
  logic                new_best_r;
  logic                wipe;
  logic                req;

  assign wipe = rst | clear;

  pun_edge #(
    .MENS_BITS(MENS_BITS)
  ) u_pun_edge (
    .clk  (clk),
    .rst  (wipe),
    .data (data),
    .req  (req)
  );

  always_ff @(posedge clk) begin
    if (wipe) begin
      state      <= IDLE;
      for (int k = 0; k < DEPTH; k++) begin
        slot[k] <= EMPTY;
      end
      valid      <= '0;
      new_s      <= '0;
      apun_r     <= '0;
      ptr        <= '0;
      count_r    <= '0;
      new_best_r <= 1'b0;
    end else begin
      new_best_r <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            new_s  <= pun;
            apun_r <= pun;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (count_r == DEPTH_C && new_s >= slot[DEPTH-1]) begin
            state <= DONE;
          end else begin
            // When full the insertion starts at the last slot and pushes its occupant out.
            ptr   <= (count_r == DEPTH_C) ? LAST_IDX : count_r[IW-1:0];
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // Strict compare keeps equal older scores ahead of the newcomer.
          if (ptr != '0 && slot[ptr - IW'(1)] > new_s) begin
            slot[ptr]  <= slot[ptr - IW'(1)];
            valid[ptr] <= valid[ptr - IW'(1)];
            ptr        <= ptr - IW'(1);
          end else begin
            slot[ptr]  <= new_s;
            valid[ptr] <= 1'b1;
            if (count_r != DEPTH_C) begin
              count_r <= count_r + CW'(1);
            end
            new_best_r <= (ptr == '0);
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_pun = EMPTY;
    for (int k = 0; k < DEPTH; k++) begin
      if (rd_idx == IW'(k) && valid[k]) begin
        rd_pun = slot[k];
      end
    end
  end

  assign mpun     = valid[0] ? slot[0] : EMPTY;
  assign apun     = apun_r;
  assign count    = count_r;
  assign busy     = (state != IDLE);
  assign new_best = new_best_r;

endmodule

// File: tb/tb_rank_table.sv
// tb/tb_rank_table.sv - directed bench for rank_table at DEPTH=4, PUN_BITS=7
module tb_rank_table;

  localparam logic [3:0] CODE = 4'b1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data;
  logic [6:0] pun;
  logic       clear;
  logic [1:0] rd_idx;
  logic [6:0] rd_pun;
  logic [6:0] mpun;
  logic [6:0] apun;
  logic [2:0] count;
  logic       busy;
  logic       new_best;

  int checks = 0;
  int errors = 0;
  int bcyc;
  bit nb;

  rank_table #(
    .MENS_BITS(4),
    .PUN_BITS (7),
    .DEPTH    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .pun      (pun),
    .clear    (clear),
    .rd_idx   (rd_idx),
    .rd_pun   (rd_pun),
    .mpun     (mpun),
    .apun     (apun),
    .count    (count),
    .busy     (busy),
    .new_best (new_best)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_slots(input string tag, input int e0, input int e1, input int e2, input int e3);
    int exp_v [4];
    exp_v = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++) begin
      rd_idx = 2'(k);
      #1;
      chk($sformatf("%s slot%0d", tag, k), 32'(rd_pun), 32'(exp_v[k]));
    end
    rd_idx = 2'd0;
  endtask

  task automatic do_event(input logic [6:0] p, output int busy_cyc, output bit saw_nb);
    data = CODE;
    pun  = p;
    step();
    data = 4'h0;
    busy_cyc = 0;
    saw_nb   = 1'b0;
    while (busy && busy_cyc < 20) begin
      if (new_best) saw_nb = 1'b1;
      busy_cyc++;
      step();
    end
  endtask

  initial begin
    rst    = 1'b1;
    clear  = 1'b0;
    data   = CODE;
    pun    = 7'd99;
    rd_idx = 2'd0;
    step();
    step();
    rst  = 1'b0;
    data = 4'h0;
    step();
    step();

    chk("reset count", 32'(count), 0);
    chk("reset mpun", 32'(mpun), 32'h7F);
    chk("reset apun", 32'(apun), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset new_best", 32'(new_best), 0);
    check_slots("reset", 127, 127, 127, 127);

    do_event(7'd50, bcyc, nb);
    chk("ins50 new_best", 32'(nb), 1);
    chk("ins50 busy_cycles", 32'(bcyc), 3);
    do_event(7'd30, bcyc, nb);
    chk("ins30 new_best", 32'(nb), 1);
    do_event(7'd70, bcyc, nb);
    chk("ins70 new_best", 32'(nb), 0);
    do_event(7'd10, bcyc, nb);
    chk("ins10 new_best", 32'(nb), 1);
    chk("ins10 worst latency", 32'(bcyc), 6);
    check_slots("fill", 10, 30, 50, 70);
    chk("fill count", 32'(count), 4);
    chk("fill apun", 32'(apun), 10);
    chk("fill mpun", 32'(mpun), 10);

    do_event(7'd80, bcyc, nb);
    chk("discard busy_cycles", 32'(bcyc), 2);
    chk("discard new_best", 32'(nb), 0);
    chk("discard apun", 32'(apun), 80);
    chk("discard count", 32'(count), 4);
    check_slots("discard", 10, 30, 50, 70);
    do_event(7'd40, bcyc, nb);
    chk("ins40 busy_cycles", 32'(bcyc), 4);
    check_slots("ins40", 10, 30, 40, 50);

    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear1 count", 32'(count), 0);
    do_event(7'd10, bcyc, nb);
    do_event(7'd30, bcyc, nb);
    do_event(7'd50, bcyc, nb);
    do_event(7'd30, bcyc, nb);
    chk("tie new_best", 32'(nb), 0);
    chk("tie count", 32'(count), 4);
    check_slots("tie", 10, 30, 30, 50);

    clear = 1'b1;
    step();
    clear = 1'b0;
    data = CODE;
    pun  = 7'd20;
    for (int c = 0; c < 6; c++) step();
    data = 4'h0;
    step();
    chk("held count", 32'(count), 1);
    chk("held apun", 32'(apun), 20);
    chk("held busy", 32'(busy), 0);
    data = CODE;
    pun  = 7'd60;
    step();
    data = 4'h0;
    step();
    data = CODE;
    pun  = 7'd5;
    step();
    data = 4'h0;
    bcyc = 0;
    while (busy && bcyc < 20) begin
      bcyc++;
      step();
    end
    step();
    chk("drop count", 32'(count), 2);
    chk("drop apun", 32'(apun), 60);
    chk("drop mpun", 32'(mpun), 20);
    check_slots("drop", 20, 60, 127, 127);

    clear = 1'b1;
    step();
    clear = 1'b0;
    do_event(7'd10, bcyc, nb);
    do_event(7'd30, bcyc, nb);
    do_event(7'd50, bcyc, nb);
    data = CODE;
    pun  = 7'd5;
    step();
    data = 4'h0;
    step();
    step();
    step();
    chk("abort pre busy", 32'(busy), 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("abort count", 32'(count), 0);
    chk("abort mpun", 32'(mpun), 32'h7F);
    chk("abort busy", 32'(busy), 0);
    chk("abort apun", 32'(apun), 0);
    check_slots("abort", 127, 127, 127, 127);

    do_event(7'd33, bcyc, nb);
    chk("recover new_best", 32'(nb), 1);
    chk("recover count", 32'(count), 1);
    chk("recover mpun", 32'(mpun), 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
